// File: rtl/jaa_pkg.sv
// Shared opcodes, ARM encodings and FSM state type for the JAA stream translator.
// JAA_WIDE_IMM_EN adds bipush/sipush support and lengthens the longest sequence.
package jaa_pkg;

    localparam logic [7:0] OP_ICONST_0 = 8'h03;
    localparam logic [7:0] OP_ICONST_5 = 8'h08;
    localparam logic [7:0] OP_BIPUSH   = 8'h10;
    localparam logic [7:0] OP_SIPUSH   = 8'h11;
    localparam logic [7:0] OP_ILOAD    = 8'h15;
    localparam logic [7:0] OP_ILOAD_0  = 8'h1A;
    localparam logic [7:0] OP_ILOAD_3  = 8'h1D;
    localparam logic [7:0] OP_ISTORE   = 8'h36;
    localparam logic [7:0] OP_ISTORE_0 = 8'h3B;
    localparam logic [7:0] OP_ISTORE_3 = 8'h3E;
    localparam logic [7:0] OP_DUP      = 8'h59;
    localparam logic [7:0] OP_SWAP     = 8'h5F;
    localparam logic [7:0] OP_IADD     = 8'h60;
    localparam logic [7:0] OP_IAND     = 8'h7E;
    localparam logic [7:0] OP_IXOR     = 8'h82;

    localparam logic [31:0] ARM_PUSH    = 32'hE92D0000;
    localparam logic [31:0] ARM_POP     = 32'hE8BD0000;
    localparam logic [31:0] ARM_MOV_IMM = 32'hE3A00000;
    localparam logic [31:0] ARM_MVN_IMM = 32'hE3E00000;
    localparam logic [31:0] ARM_ORR_IMM = 32'hE3800000;
    localparam logic [31:0] ARM_MOV_REG = 32'hE1A00000;
    localparam logic [31:0] ARM_LDR     = 32'hE5900000;
    localparam logic [31:0] ARM_STR     = 32'hE5800000;
    localparam logic [31:0] ARM_ADD     = 32'hE0800000;
    localparam logic [31:0] ARM_AND     = 32'hE0000000;
    localparam logic [31:0] ARM_EOR     = 32'hE0200000;
    localparam logic [3:0]  ARM_SP      = 4'd13;

`ifdef JAA_WIDE_IMM_EN
    localparam int MAX_SEQ = 5;
`else
    localparam int MAX_SEQ = 3;
`endif

    typedef enum logic [1:0] {OPCODE, OPND1, OPND2, EMIT} state_e;

    function automatic logic [31:0] reg_mask(input logic [3:0] r);
        return 32'd1 << r;
    endfunction

    // Immediate data-processing: rot is the 4-bit rotate field (value ror 2*rot).
    function automatic logic [31:0] enc_imm(input logic [31:0] prefix, input logic [3:0] rd,
                                            input logic [3:0] rn, input logic [7:0] imm,
                                            input logic [3:0] rot);
        return prefix | {12'd0, rn, rd, rot, imm};
    endfunction

    function automatic logic [31:0] enc_mem(input logic [31:0] prefix, input logic [3:0] rd,
                                            input logic [3:0] rn, input logic [11:0] off);
        return prefix | {12'd0, rn, rd, off};
    endfunction

    function automatic logic [31:0] enc_dp(input logic [31:0] prefix, input logic [3:0] rd,
                                           input logic [3:0] rn, input logic [3:0] rm);
        return prefix | {12'd0, rn, rd, 8'd0, rm};
    endfunction

    // mov rd, rm, lsl/asr #16
    function automatic logic [31:0] enc_shift16(input logic [3:0] rd, input logic [3:0] rm,
                                                input logic is_asr);
        return ARM_MOV_REG | {16'd0, rd, 5'd16, is_asr, 1'b0, 1'b0, rm};
    endfunction

endpackage

// File: rtl/jaa_word_fifo.sv
// Output FIFO for translated words: array storage with a registered head stage,
// occupancy counted across both, registered full and storage-empty flags.
module jaa_word_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] head_q;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    mem_cnt_q, mem_cnt_d;
    logic             head_valid_q, head_valid_d;
    logic             full_q, mem_empty_q;
    logic             push_ok, pop_ok, load;

    always_comb begin
        push_ok      = push_i && !full_q;
        pop_ok       = pop_i && head_valid_q;
        load         = !mem_empty_q && (!head_valid_q || pop_ok);
        mem_cnt_d    = mem_cnt_q + CW'(push_ok) - CW'(load);
        head_valid_d = load || (head_valid_q && !pop_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // A push is refused on a full cycle even if the head leaves in that same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_cnt_q    <= '0;
            head_valid_q <= 1'b0;
            head_q       <= '0;
            full_q       <= 1'b0;
            mem_empty_q  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (load) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                head_q   <= mem_q[rd_ptr_q];
            end
            mem_cnt_q    <= mem_cnt_d;
            head_valid_q <= head_valid_d;
            full_q       <= (mem_cnt_d + CW'(head_valid_d)) == DEPTH_C;
            mem_empty_q  <= (mem_cnt_d == '0);
        end
    end

    assign full_o  = full_q;
    assign valid_o = head_valid_q;
    assign data_o  = head_q;

endmodule

// File: rtl/jaa_stream_translator.sv
// Streaming bytecode-to-ARM translator: one byte per handshake in, ARM words out via a FIFO.
// JAA_WIDE_IMM_EN enables bipush/sipush; without it they take the error path.
module jaa_stream_translator
    import jaa_pkg::*;
#(
    parameter int OUT_DEPTH  = 8,
    parameter int DATA_REG   = 1,
    parameter int AUX_REG    = 2,
    parameter int LOCALS_REG = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_last,
    output logic        err_valid,
    output logic [7:0]  err_opcode,
    output logic [15:0] bc_count
);
    localparam int IDX_W = $clog2(MAX_SEQ);
    localparam logic [3:0]  RD = 4'(DATA_REG);
    localparam logic [3:0]  RA = 4'(AUX_REG);
    localparam logic [3:0]  RL = 4'(LOCALS_REG);
    localparam logic [31:0] W_PUSH_D  = ARM_PUSH | reg_mask(RD);
    localparam logic [31:0] W_PUSH_A  = ARM_PUSH | reg_mask(RA);
    localparam logic [31:0] W_POP_D   = ARM_POP | reg_mask(RD);
    localparam logic [31:0] W_POP_DA  = ARM_POP | reg_mask(RD) | reg_mask(RA);

    state_e             state_q;
    logic [7:0]         opcode_q, opnd1_q;
`ifdef JAA_WIDE_IMM_EN
    logic [7:0]         opnd2_q;
`endif
    logic [IDX_W-1:0]   widx_q;
    logic               err_valid_q;
    logic [7:0]         err_opcode_q;
    logic [15:0]        bc_count_q;

    logic               zero_op, opnd_op, fifo_full, push, word_last;
    logic [2:0]         widx, last_idx;
    logic [7:0]         op_idx;
    logic [31:0]        seq_word, dp_prefix;

    always_comb begin
        zero_op = in_byte inside {[OP_ICONST_0:OP_ICONST_5], [OP_ILOAD_0:OP_ILOAD_3],
                                  [OP_ISTORE_0:OP_ISTORE_3], OP_DUP, OP_SWAP,
                                  OP_IADD, OP_IAND, OP_IXOR};
        opnd_op = in_byte inside {OP_ILOAD, OP_ISTORE};
`ifdef JAA_WIDE_IMM_EN
        opnd_op = opnd_op || (in_byte inside {OP_BIPUSH, OP_SIPUSH});
`endif
    end

    assign widx = 3'(widx_q);

    // Word for the current index of the latched bytecode; most sequences end in push {D}.
    always_comb begin
        seq_word  = W_PUSH_D;
        last_idx  = 3'd1;
        op_idx    = 8'd0;
        dp_prefix = (opcode_q == OP_IADD) ? ARM_ADD : (opcode_q == OP_IAND) ? ARM_AND : ARM_EOR;
        if (opcode_q >= OP_ICONST_0 && opcode_q <= OP_ICONST_5) begin
            if (widx == 3'd0) seq_word = enc_imm(ARM_MOV_IMM, RD, 4'd0, opcode_q - OP_ICONST_0, 4'd0);
        end else if (opcode_q == OP_ILOAD || (opcode_q >= OP_ILOAD_0 && opcode_q <= OP_ILOAD_3)) begin
            op_idx = (opcode_q == OP_ILOAD) ? opnd1_q : opcode_q - OP_ILOAD_0;
            if (widx == 3'd0) seq_word = enc_mem(ARM_LDR, RD, RL, {2'b00, op_idx, 2'b00});
        end else if (opcode_q == OP_ISTORE || (opcode_q >= OP_ISTORE_0 && opcode_q <= OP_ISTORE_3)) begin
            op_idx   = (opcode_q == OP_ISTORE) ? opnd1_q : opcode_q - OP_ISTORE_0;
            seq_word = (widx == 3'd0) ? W_POP_D : enc_mem(ARM_STR, RD, RL, {2'b00, op_idx, 2'b00});
        end else if (opcode_q inside {OP_IADD, OP_IAND, OP_IXOR}) begin
            last_idx = 3'd2;
            if (widx == 3'd0)      seq_word = W_POP_DA;
            else if (widx == 3'd1) seq_word = enc_dp(dp_prefix, RD, RD, RA);
        end else if (opcode_q == OP_DUP) begin
            if (widx == 3'd0) seq_word = enc_mem(ARM_LDR, RD, ARM_SP, 12'd0);
        end else if (opcode_q == OP_SWAP) begin
            last_idx = 3'd2;
            if (widx == 3'd0)      seq_word = W_POP_DA;
            else if (widx == 3'd2) seq_word = W_PUSH_A;
`ifdef JAA_WIDE_IMM_EN
        end else if (opcode_q == OP_BIPUSH) begin
            if (widx == 3'd0) seq_word = opnd1_q[7] ? enc_imm(ARM_MVN_IMM, RD, 4'd0, ~opnd1_q, 4'd0)
                                                    : enc_imm(ARM_MOV_IMM, RD, 4'd0, opnd1_q, 4'd0);
        end else if (opcode_q == OP_SIPUSH) begin
            // A negative hi byte needs the sign spread from bit 15 through bit 31.
            last_idx = opnd1_q[7] ? 3'd4 : 3'd2;
            if (widx == 3'd0)                     seq_word = enc_imm(ARM_MOV_IMM, RD, 4'd0, opnd2_q, 4'd0);
            else if (widx == 3'd1)                seq_word = enc_imm(ARM_ORR_IMM, RD, RD, opnd1_q, 4'hC);
            else if (widx == 3'd2 && opnd1_q[7])  seq_word = enc_shift16(RD, RD, 1'b0);
            else if (widx == 3'd3)                seq_word = enc_shift16(RD, RD, 1'b1);
`endif
        end
    end

    assign word_last = (widx == last_idx);
    assign push      = (state_q == EMIT) && !fifo_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= OPCODE;
            opcode_q     <= 8'd0;
            opnd1_q      <= 8'd0;
`ifdef JAA_WIDE_IMM_EN
            opnd2_q      <= 8'd0;
`endif
            widx_q       <= '0;
            err_valid_q  <= 1'b0;
            err_opcode_q <= 8'd0;
            bc_count_q   <= 16'd0;
        end else begin
            err_valid_q <= 1'b0;
            case (state_q)
                OPCODE: if (in_valid) begin
                    opcode_q <= in_byte;
                    widx_q   <= '0;
                    if (zero_op) begin
                        state_q <= EMIT;
                    end else if (opnd_op) begin
                        state_q <= OPND1;
                    end else begin
                        err_valid_q  <= 1'b1;
                        err_opcode_q <= in_byte;
                    end
                end
                OPND1: if (in_valid) begin
                    opnd1_q <= in_byte;
                    state_q <= (opcode_q == OP_SIPUSH) ? OPND2 : EMIT;
                end
                OPND2: if (in_valid) begin
`ifdef JAA_WIDE_IMM_EN
                    opnd2_q <= in_byte;
`endif
                    state_q <= EMIT;
                end
                EMIT: if (!fifo_full) begin
                    if (word_last) begin
                        state_q    <= OPCODE;
                        bc_count_q <= bc_count_q + 16'd1;
                    end else begin
                        widx_q <= widx_q + IDX_W'(1);
                    end
                end
                default: state_q <= OPCODE;
            endcase
        end
    end

    jaa_word_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (33)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  ({word_last, seq_word}),
        .full_o  (fifo_full),
        .pop_i   (out_ready),
        .valid_o (out_valid),
        .data_o  ({out_last, out_word})
    );

    assign in_ready   = (state_q != EMIT);
    assign err_valid  = err_valid_q;
    assign err_opcode = err_opcode_q;
    assign bc_count   = bc_count_q;

endmodule

// File: tb/tb_jaa_stream_translator.sv
// Scoreboard bench for jaa_stream_translator: expected words queued at stimulus, checked on drain.
module tb_jaa_stream_translator;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_byte = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_word;
    logic        out_last;
    logic        err_valid;
    logic [7:0]  err_opcode;
    logic [15:0] bc_count;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          last_hs = 0;
    logic        rnd_ready = 1'b0;
    logic [15:0] exp_bc = 16'd0;
    logic [32:0] exp_q[$];
    logic [7:0]  op_tab [16] = '{8'h03, 8'h08, 8'h1A, 8'h1D, 8'h3B, 8'h3E, 8'h59, 8'h5F,
                                 8'h60, 8'h7E, 8'h82, 8'h15, 8'h36, 8'h05, 8'h1C, 8'h3C};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    jaa_stream_translator #(.OUT_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_byte    (in_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_last   (out_last),
        .err_valid  (err_valid),
        .err_opcode (err_opcode),
        .bc_count   (bc_count)
    );

    // Monitor: a word transfers at the next edge whenever valid and ready are seen here.
    initial begin
        logic [32:0] exp;
        forever begin
            @(negedge clk);
            if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_word got %08h last %0b required no word", out_word, out_last);
                end else begin
                    exp = exp_q.pop_front();
                    if ({out_last, out_word} !== exp) begin
                        miscompares++;
                        $display("FAIL word got %08h last %0b required %08h last %0b",
                                 out_word, out_last, exp[31:0], exp[32]);
                    end else begin
                        $display("word %08h last %0b", out_word, out_last);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference expansion with default registers D=1, A=2, L=4.
    task automatic expect_op(input logic [7:0] op, input logic [7:0] o1);
        logic [31:0] off;
        exp_bc++;
        if (op >= 8'h03 && op <= 8'h08) begin
            exp_q.push_back({1'b0, 32'hE3A01000 | 32'(op - 8'h03)});
            exp_q.push_back({1'b1, 32'hE92D0002});
        end else if (op == 8'h15 || (op >= 8'h1A && op <= 8'h1D)) begin
            off = (op == 8'h15) ? 32'(o1) * 4 : 32'(op - 8'h1A) * 4;
            exp_q.push_back({1'b0, 32'hE5941000 | off});
            exp_q.push_back({1'b1, 32'hE92D0002});
        end else if (op == 8'h36 || (op >= 8'h3B && op <= 8'h3E)) begin
            off = (op == 8'h36) ? 32'(o1) * 4 : 32'(op - 8'h3B) * 4;
            exp_q.push_back({1'b0, 32'hE8BD0002});
            exp_q.push_back({1'b1, 32'hE5841000 | off});
        end else if (op == 8'h60 || op == 8'h7E || op == 8'h82) begin
            exp_q.push_back({1'b0, 32'hE8BD0006});
            exp_q.push_back({1'b0, (op == 8'h60) ? 32'hE0811002 : (op == 8'h7E) ? 32'hE0011002 : 32'hE0211002});
            exp_q.push_back({1'b1, 32'hE92D0002});
        end else if (op == 8'h59) begin
            exp_q.push_back({1'b0, 32'hE59D1000});
            exp_q.push_back({1'b1, 32'hE92D0002});
        end else begin
            exp_q.push_back({1'b0, 32'hE8BD0006});
            exp_q.push_back({1'b0, 32'hE92D0002});
            exp_q.push_back({1'b1, 32'hE92D0004});
        end
    endtask

    task automatic send(input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        while (in_ready !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL send_timeout byte %02h in_ready %b required 1", b, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        last_hs  = cyc;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain outstanding %0d words required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_idle out_valid %b required 0", out_valid);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({in_ready, out_valid, out_last, err_valid, err_opcode, bc_count} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000}) begin
            miscompares++;
            $display("FAIL reset_state got rdy %b vld %b last %b err %b op %02h bc %0d required 1 0 0 0 00 0",
                     in_ready, out_valid, out_last, err_valid, err_opcode, bc_count);
        end
    endtask

    task automatic test_iconst();
        expect_op(8'h04, 8'h00);
        send(8'h04);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== (i == 2)) begin
                miscompares++;
                $display("FAIL latency cycle %0d out_valid %b required %0b", i, out_valid, i == 2);
            end
        end
        vectors++;
        if (out_word !== 32'hE3A01001 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL first_head got %08h last %b required E3A01001 last 0", out_word, out_last);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();
        vectors++;
        if (bc_count !== exp_bc) begin
            miscompares++;
            $display("FAIL bc_iconst got %0d required %0d", bc_count, exp_bc);
        end
    endtask

    task automatic test_iload_istore();
        int h0;
        expect_op(8'h15, 8'h05);
        expect_op(8'h36, 8'h02);
        send(8'h15);
        h0 = last_hs;
        send(8'h05);
        send(8'h36);
        vectors++;
        if (last_hs - h0 !== 4) begin
            miscompares++;
            $display("FAIL iload_occupancy got %0d cycles required 4", last_hs - h0);
        end
        send(8'h02);
        drain();
    endtask

    task automatic test_arith_swap();
        int h0;
        expect_op(8'h60, 8'h00);
        expect_op(8'h5F, 8'h00);
        send(8'h60);
        h0 = last_hs;
        send(8'h5F);
        vectors++;
        if (last_hs - h0 !== 4) begin
            miscompares++;
            $display("FAIL iadd_occupancy got %0d cycles required 4", last_hs - h0);
        end
        drain();
        vectors++;
        if (bc_count !== exp_bc) begin
            miscompares++;
            $display("FAIL bc_arith got %0d required %0d", bc_count, exp_bc);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 8; i++) expect_op(8'h03, 8'h00);
        for (int i = 0; i < 3; i++) send(8'h03);
        repeat (4) @(negedge clk);
        held = out_word;
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL full_stall in_ready %b out_valid %b required 0 1", in_ready, out_valid);
        end
        @(negedge clk);
        vectors++;
        if (out_word !== 32'hE3A01000 || out_word !== held) begin
            miscompares++;
            $display("FAIL head_hold got %08h required E3A01000", out_word);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(8'h03);
        drain();
        vectors++;
        if (bc_count !== exp_bc) begin
            miscompares++;
            $display("FAIL bc_backpressure got %0d required %0d", bc_count, exp_bc);
        end
    endtask

    task automatic test_error();
        send(8'hB1);
        @(negedge clk);
        vectors++;
        if (err_valid !== 1'b1 || err_opcode !== 8'hB1 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL err_pulse err %b op %02h rdy %b required 1 B1 1", err_valid, err_opcode, in_ready);
        end
        in_valid = 1'b1;
        in_byte  = 8'h59;
        expect_op(8'h59, 8'h00);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (err_valid !== 1'b0 || err_opcode !== 8'hB1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL err_end err %b op %02h rdy %b required 0 B1 0", err_valid, err_opcode, in_ready);
        end
        drain();
        vectors++;
        if (bc_count !== exp_bc) begin
            miscompares++;
            $display("FAIL bc_error got %0d required %0d", bc_count, exp_bc);
        end
    endtask

    task automatic test_wide_imm();
`ifdef JAA_WIDE_IMM_EN
        exp_q.push_back({1'b0, 32'hE3E01001});
        exp_q.push_back({1'b1, 32'hE92D0002});
        exp_q.push_back({1'b0, 32'hE3A01005});
        exp_q.push_back({1'b1, 32'hE92D0002});
        exp_q.push_back({1'b0, 32'hE3A01034});
        exp_q.push_back({1'b0, 32'hE3811C12});
        exp_q.push_back({1'b1, 32'hE92D0002});
        exp_q.push_back({1'b0, 32'hE3A01000});
        exp_q.push_back({1'b0, 32'hE3811C80});
        exp_q.push_back({1'b0, 32'hE1A01801});
        exp_q.push_back({1'b0, 32'hE1A01841});
        exp_q.push_back({1'b1, 32'hE92D0002});
        exp_bc += 16'd4;
        send(8'h10); send(8'hFE);
        send(8'h10); send(8'h05);
        send(8'h11); send(8'h12); send(8'h34);
        send(8'h11); send(8'h80); send(8'h00);
`else
        send(8'h10);
        @(negedge clk);
        vectors++;
        if (err_valid !== 1'b1 || err_opcode !== 8'h10) begin
            miscompares++;
            $display("FAIL bipush_unsupported err %b op %02h required 1 10", err_valid, err_opcode);
        end
        expect_op(8'h04, 8'h00);
        send(8'h04);
`endif
        drain();
        vectors++;
        if (bc_count !== exp_bc) begin
            miscompares++;
            $display("FAIL bc_wide got %0d required %0d", bc_count, exp_bc);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] op, idx;
        rnd_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            op  = op_tab[$urandom_range(0, 15)];
            idx = 8'($urandom_range(0, 255));
            expect_op(op, idx);
            send(op);
            if (op == 8'h15 || op == 8'h36) send(idx);
        end
        rnd_ready = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();
        vectors++;
        if (bc_count !== exp_bc) begin
            miscompares++;
            $display("FAIL bc_stream got %0d required %0d", bc_count, exp_bc);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(8'h60);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        exp_bc = 16'd0;
        @(negedge clk);
        vectors++;
        if ({in_ready, out_valid, out_last, err_valid, err_opcode, bc_count} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000}) begin
            miscompares++;
            $display("FAIL mid_reset got rdy %b vld %b last %b err %b op %02h bc %0d required 1 0 0 0 00 0",
                     in_ready, out_valid, out_last, err_valid, err_opcode, bc_count);
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_dropped out_valid %b required 0", out_valid);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        expect_op(8'h08, 8'h00);
        send(8'h08);
        drain();
        vectors++;
        if (bc_count !== exp_bc) begin
            miscompares++;
            $display("FAIL bc_after_reset got %0d required %0d", bc_count, exp_bc);
        end
    endtask

    initial begin
        test_reset();
        test_iconst();
        test_iload_istore();
        test_arith_swap();
        test_backpressure();
        test_error();
        test_wide_imm();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jaa_stream_translator.md
# jaa_stream_translator

Streaming Java-bytecode-to-ARM translator: the next-generation JAA front end. It accepts bytecode one byte per valid/ready handshake instead of reading an internal ROM, and expands each supported opcode into a sequence of 32-bit ARM words. Words go into a parametrised output FIFO drained by a valid/ready consumer, typically the instruction memory writer. Each opcode's sequence is tagged with `out_last`, and unsupported opcodes are reported without stalling the stream.

## Interface
Parameters:
- `OUT_DEPTH`, 8: output FIFO depth in words; power of two, minimum 4.
- `DATA_REG`, 1: ARM scratch register index for the top-of-stack value.
- `AUX_REG`, 2: second scratch register for binary operations.
- `LOCALS_REG`, 4: ARM register holding the base address of the locals array.

Ports (reset is synchronous, active-high; clock is `clk`):
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: bytecode byte valid.
- `in_ready` out 1: translator accepts a byte.
- `in_byte` in 8: bytecode byte.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: consumer takes the head.
- `out_word` out 32: ARM instruction.
- `out_last` out 1: head is the final word of its bytecode's expansion.
- `err_valid` out 1: one-cycle pulse on an unsupported opcode.
- `err_opcode` out 8: offending opcode; held until the next error.
- `bc_count` out 16: bytecodes completed, wraps at 2^16.

## Operation
- FSM states: `OPCODE`, `OPND1`, `OPND2`, `EMIT`.
- `in_ready` = 1 in `OPCODE`, `OPND1` and `OPND2`; 0 in `EMIT`.
- `OPCODE`: decode the accepted byte.
  - Zero-operand opcodes go to `EMIT`.
  - `iload` (0x15), `istore` (0x36) and `bipush` (0x10) go to `OPND1`.
  - `sipush` (0x11) goes to `OPND1` and then `OPND2`.
  - Unsupported opcodes raise `err_valid` for one cycle, load `err_opcode`, stay in `OPCODE` and emit nothing.
- `EMIT`: a word index walks the sequence, pushing one word per cycle while the FIFO is not full. The last word is pushed with `out_last` = 1, then the FSM returns to `OPCODE` and `bc_count` increments.
- Notation below: D = `DATA_REG`, A = `AUX_REG`, L = `LOCALS_REG`, off = 4 × index. Locals are word-addressed.
- Sequences:
  - `iconst_n` (0x03–0x08): `mov D,#n`; `push {D}`.
  - `iload_n` (0x1A–0x1D) and `iload idx`: `ldr D,[L,#off]`; `push {D}`.
  - `istore_n` (0x3B–0x3E) and `istore idx`: `pop {D}`; `str D,[L,#off]`.
  - `iadd` (0x60), `iand` (0x7E), `ixor` (0x82): `pop {D,A}`; then `add`, `and` or `eor` as `D,D,A`; then `push {D}`.
  - `dup` (0x59): `ldr D,[sp]`; `push {D}`.
  - `swap` (0x5F): `pop {D,A}`; `push {D}`; `push {A}`.
- Encodings with default registers:
  - push: E92D0000 | mask. pop: E8BD0000 | mask.
  - `mov D,#i`: E3A01000 | i. `mvn D,#i`: E3E01000 | i.
  - `ldr D,[L,#off]`: E5941000 | off. `str D,[L,#off]`: E5841000 | off. `ldr D,[sp]`: E59D1000.
  - `add`: E0811002. `and`: E0011002. `eor`: E0211002.
  - Register fields come from the parameters.
- `reset`, including mid-`EMIT`:
  - FSM returns to `OPCODE` and any partial sequence is dropped.
  - FIFO is flushed.
  - `out_valid`, `out_last`, `err_valid`, `err_opcode` and `bc_count` are all 0.
  - `in_ready` is 1 from the first cycle after reset.

## Timing
- With an empty FIFO, the first word is visible on `out_valid` 2 cycles after the opcode handshake edge.
- A bytecode with k operand bytes and N words occupies the input for 1 + k + N cycles when there is no backpressure.
- FIFO full: `EMIT` holds the word index and no word is lost.
- FIFO simultaneous push and pop while full: the push is refused in that cycle. Only registered occupancy is used.
- `out_word` and `out_last` hold stable while `out_valid` = 1 and `out_ready` = 0.

## Configuration
- `JAA_WIDE_IMM_EN` defined: `bipush` and `sipush` are supported.
  - `bipush b`, b ≥ 0: `mov D,#b`; `push`.
  - `bipush b`, b < 0: `mvn D,#(~b & 0xFF)`; `push`.
  - `sipush hi,lo`: `mov D,#lo`; `orr D,D,#hi<<8` (E3811C00 | hi).
  - If hi[7] = 1, `sipush` also emits `lsl D,D,#16` (E1A01801) and `asr D,D,#16` (E1A01841).
  - Every `sipush` ends with `push {D}`. The maximum sequence length is 5.
- `JAA_WIDE_IMM_EN` undefined: 0x10 and 0x11 are unsupported, take the error path, and their operand bytes are then decoded as opcodes. The maximum sequence length is 3.

## Structure
- Package `jaa_pkg` holds:
  - opcode localparams;
  - ARM prefix constants for push, pop, mov, mvn, ldr, str and data-processing;
  - the FSM state enum;
  - the `MAX_SEQ` constant;
  - the encoding functions.
- Sub-module `jaa_word_fifo`: 33-bit wide (word plus last flag), `OUT_DEPTH` deep, synchronous reset, registered full/empty flags.

## Test plan
- Stream 0x04 → E3A01001, then E92D0002 with `out_last` = 1; `bc_count` = 1.
- Stream 0x15 0x05 → E5941014, E92D0002. Stream 0x36 0x02 → E8BD0002, E5841008.
- Stream 0x60, then 0x5F → E8BD0006, E0811002, E92D0002, then E8BD0006, E92D0002, E92D0004.
- `OUT_DEPTH` = 4, `out_ready` = 0, stream 8×0x03 → `in_ready` drops once the FIFO is full. After release, 16 words arrive in order with no loss or duplication.
- Stream 0xB1 → `err_valid` pulses for one cycle, `err_opcode` = B1, no words, and the next byte is accepted the following cycle.
- `JAA_WIDE_IMM_EN` defined:
  - 0x10 0xFE → E3E01001, E92D0002.
  - 0x11 0x12 0x34 → E3A01034, E3811C12, E92D0002.
  - 0x11 0x80 0x00 → E3A01000, E3811C80, E1A01801, E1A01841, E92D0002.
  - Assert `reset` mid-sequence → FIFO empties and all outputs return to 0.
